// File: rtl/vx_raster_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vx_raster_pkg : shared raster types, scheduler state encoding, helpers
// Revision 1.0
// ---------------------------------------------------------------------------
package vx_raster_pkg;

    localparam int RASTER_SCHED_STATE_BITS = 2;

    typedef enum logic [RASTER_SCHED_STATE_BITS-1:0] {
        RASTER_SCHED_IDLE  = 2'd0,
        RASTER_SCHED_FETCH = 2'd1,
        RASTER_SCHED_RSP   = 2'd2
    } raster_sched_state_e;

    typedef struct packed {
        logic [7:0] pos_x;
        logic [7:0] pos_y;
        logic [3:0] mask;
    } raster_stamp_t;

    function automatic int log2up(input int x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vx_priority_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vx_priority_encoder : index of the lowest set bit, plus any-set flag
// Revision 1.0
// ---------------------------------------------------------------------------
module vx_priority_encoder #(
    parameter int N         = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [N-1:0]         data_in,
    output logic [IDX_WIDTH-1:0] index,
    output logic                 valid
);

    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (data_in[i]) begin
                index = IDX_WIDTH'(i);
                valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vx_raster_stamp_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vx_raster_stamp_sched : hands raster stamps to a warp's non-empty lane
// groups as CSR writes, then reports which threads received a stamp.
// Revision 1.0
// ---------------------------------------------------------------------------
module vx_raster_stamp_sched
    import vx_raster_pkg::*;
#(
    parameter int CORE_ID     = 0,
    parameter int NUM_THREADS = 4,
    parameter int NUM_LANES   = 1,
    parameter int NW_WIDTH    = 2,
    parameter int UUID_WIDTH  = 8,
    parameter int PID_WIDTH   = log2up(NUM_THREADS / NUM_LANES)
) (
    input  logic                            clk,
    input  logic                            reset_n,

    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [NW_WIDTH-1:0]             req_wid,
    input  logic [NUM_THREADS-1:0]          req_tmask,
    input  logic [UUID_WIDTH-1:0]           req_uuid,

    input  logic                            stamp_valid,
    output logic                            stamp_ready,
    input  logic [NUM_LANES-1:0]            stamp_mask,
    input  raster_stamp_t [NUM_LANES-1:0]   stamp_data,
    input  logic                            stamp_done,

    output logic                            write_enable,
    output logic [UUID_WIDTH-1:0]           write_uuid,
    output logic [NW_WIDTH-1:0]             write_wid,
    output logic [NUM_LANES-1:0]            write_tmask,
    output logic [PID_WIDTH-1:0]            write_pid,
    output raster_stamp_t [NUM_LANES-1:0]   write_data,

    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [NW_WIDTH-1:0]             rsp_wid,
    output logic [UUID_WIDTH-1:0]           rsp_uuid,
    output logic [NUM_THREADS-1:0]          rsp_tmask
);

    localparam int NUM_GROUPS = NUM_THREADS / NUM_LANES;

    raster_sched_state_e        r_state;
    raster_sched_state_e        w_state_next;
    logic [PID_WIDTH-1:0]       r_pid;
    logic [NW_WIDTH-1:0]        r_wid;
    logic [UUID_WIDTH-1:0]      r_uuid;
    logic [NUM_THREADS-1:0]     r_tmask;
    logic [NUM_THREADS-1:0]     r_acc;
    logic [NUM_GROUPS-1:0]      w_search;
    logic [PID_WIDTH-1:0]       w_next_pid;
    logic                       w_next_valid;
    logic [NUM_LANES-1:0]       w_hit;
    logic                       w_fire;

    assign w_hit  = r_tmask[r_pid*NUM_LANES +: NUM_LANES] & stamp_mask;
    assign w_fire = (r_state == RASTER_SCHED_FETCH) && stamp_valid;

    // In IDLE search the incoming mask from group 0; in FETCH only above pid.
    always_comb begin
        w_search = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (r_state == RASTER_SCHED_IDLE) begin
                w_search[g] = |req_tmask[g*NUM_LANES +: NUM_LANES];
            end else begin
                w_search[g] = (|r_tmask[g*NUM_LANES +: NUM_LANES]) && (g > int'(r_pid));
            end
        end
    end

    // CORE_ID only tags the instance; any non-negative id builds the encoder.
    if (CORE_ID >= 0) begin : g_penc
        vx_priority_encoder #(
            .N         (NUM_GROUPS),
            .IDX_WIDTH (PID_WIDTH)
        ) u_penc (
            .data_in (w_search),
            .index   (w_next_pid),
            .valid   (w_next_valid)
        );
    end else begin : g_penc_off
        assign w_next_pid   = '0;
        assign w_next_valid = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RASTER_SCHED_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RASTER_SCHED_IDLE: begin
                if (req_valid) begin
                    w_state_next = w_next_valid ? RASTER_SCHED_FETCH : RASTER_SCHED_RSP;
                end
            end
            RASTER_SCHED_FETCH: begin
                if (stamp_valid) begin
                    if (stamp_done || !w_next_valid) begin
                        w_state_next = RASTER_SCHED_RSP;
                    end
                end else if (stamp_done) begin
                    w_state_next = RASTER_SCHED_RSP;
                end
            end
            RASTER_SCHED_RSP: begin
                if (rsp_ready) begin
                    w_state_next = RASTER_SCHED_IDLE;
                end
            end
            default: w_state_next = RASTER_SCHED_IDLE;
        endcase
    end

    // reset_n gates req_ready so nothing is accepted while reset is held.
    always_comb begin
        req_ready   = (r_state == RASTER_SCHED_IDLE) && reset_n;
        stamp_ready = (r_state == RASTER_SCHED_FETCH);
        rsp_valid   = (r_state == RASTER_SCHED_RSP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pid        <= '0;
            r_wid        <= '0;
            r_uuid       <= '0;
            r_tmask      <= '0;
            r_acc        <= '0;
            write_enable <= 1'b0;
            write_pid    <= '0;
            write_tmask  <= '0;
            write_data   <= '0;
        end else begin
            write_enable <= w_fire;
            if ((r_state == RASTER_SCHED_IDLE) && req_valid) begin
                r_wid   <= req_wid;
                r_uuid  <= req_uuid;
                r_tmask <= req_tmask;
                r_acc   <= '0;
                r_pid   <= w_next_pid;
            end
            if (w_fire) begin
                write_pid   <= r_pid;
                write_tmask <= w_hit;
                write_data  <= stamp_data;
                r_acc[r_pid*NUM_LANES +: NUM_LANES] <= r_acc[r_pid*NUM_LANES +: NUM_LANES] | w_hit;
                if (w_next_valid) begin
                    r_pid <= w_next_pid;
                end
            end
        end
    end

    assign write_wid  = r_wid;
    assign write_uuid = r_uuid;
    assign rsp_wid    = r_wid;
    assign rsp_uuid   = r_uuid;
    assign rsp_tmask  = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_vx_raster_stamp_sched.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for vx_raster_stamp_sched with NUM_THREADS=4, NUM_LANES=2.
module tb_vx_raster_stamp_sched;
    import vx_raster_pkg::*;

    localparam int NT = 4;
    localparam int NL = 2;
    localparam int NW = 2;
    localparam int UW = 8;
    localparam int PW = 1;
    localparam int NG = NT / NL;
    localparam int RW = $bits(raster_stamp_t);

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    req_valid = 1'b0;
    logic                    req_ready;
    logic [NW-1:0]           req_wid = '0;
    logic [NT-1:0]           req_tmask = '0;
    logic [UW-1:0]           req_uuid = '0;
    logic                    stamp_valid = 1'b0;
    logic                    stamp_ready;
    logic [NL-1:0]           stamp_mask = '0;
    raster_stamp_t [NL-1:0]  stamp_data = '0;
    logic                    stamp_done = 1'b0;
    logic                    write_enable;
    logic [UW-1:0]           write_uuid;
    logic [NW-1:0]           write_wid;
    logic [NL-1:0]           write_tmask;
    logic [PW-1:0]           write_pid;
    raster_stamp_t [NL-1:0]  write_data;
    logic                    rsp_valid;
    logic                    rsp_ready = 1'b0;
    logic [NW-1:0]           rsp_wid;
    logic [UW-1:0]           rsp_uuid;
    logic [NT-1:0]           rsp_tmask;

    always #5 clk = ~clk;

    vx_raster_stamp_sched #(
        .CORE_ID     (0),
        .NUM_THREADS (NT),
        .NUM_LANES   (NL),
        .NW_WIDTH    (NW),
        .UUID_WIDTH  (UW),
        .PID_WIDTH   (PW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wid      (req_wid),
        .req_tmask    (req_tmask),
        .req_uuid     (req_uuid),
        .stamp_valid  (stamp_valid),
        .stamp_ready  (stamp_ready),
        .stamp_mask   (stamp_mask),
        .stamp_data   (stamp_data),
        .stamp_done   (stamp_done),
        .write_enable (write_enable),
        .write_uuid   (write_uuid),
        .write_wid    (write_wid),
        .write_tmask  (write_tmask),
        .write_pid    (write_pid),
        .write_data   (write_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_wid      (rsp_wid),
        .rsp_uuid     (rsp_uuid),
        .rsp_tmask    (rsp_tmask)
    );

    typedef struct {
        logic [PW-1:0]    pid;
        logic [NL-1:0]    tmask;
        logic [NL*RW-1:0] data;
        logic [NW-1:0]    wid;
        logic [UW-1:0]    uuid;
        int               cyc;
    } wr_t;

    typedef struct {
        logic [NW-1:0] wid;
        logic [UW-1:0] uuid;
        logic [NT-1:0] tmask;
        int            cyc;
    } rsp_t;

    wr_t  wq[$];
    rsp_t rq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   stall_req = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops expected writes/responses whenever the DUT presents them.
    always @(negedge clk) begin : mon
        wr_t            we;
        rsp_t           re;
        logic           r;
        static logic    seen = 1'b0;
        static logic    stalled = 1'b0;
        static logic [NW+UW+NT-1:0] held = '0;
        if (!reset_n) begin
            seen    = 1'b0;
            stalled = 1'b0;
        end else begin
            if (write_enable) begin
                if (wq.size() == 0) begin
                    flag("unexpected_write");
                end else begin
                    we = wq.pop_front();
                    chk("write_pid",   64'(write_pid),   64'(we.pid));
                    chk("write_tmask", 64'(write_tmask), 64'(we.tmask));
                    chk("write_data",  64'(write_data),  64'(we.data));
                    chk("write_wid",   64'(write_wid),   64'(we.wid));
                    chk("write_uuid",  64'(write_uuid),  64'(we.uuid));
                    chk("write_cycle", 64'(cyc),         64'(we.cyc));
                end
            end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
                we = wq.pop_front();
                chk("write_missing", 64'(0), 64'(1));
            end

            if (rsp_valid) begin
                chk("busy_req_ready",   64'(req_ready),   64'(0));
                chk("busy_stamp_ready", 64'(stamp_ready), 64'(0));
                if (rq.size() == 0) begin
                    flag("unexpected_rsp");
                    rsp_ready = 1'b1;
                end else begin
                    re = rq[0];
                    if (!seen) chk("rsp_cycle", 64'(cyc), 64'(re.cyc));
                    if (stalled) chk("rsp_hold", 64'({rsp_wid, rsp_uuid, rsp_tmask}), 64'(held));
                    chk("rsp_wid",   64'(rsp_wid),   64'(re.wid));
                    chk("rsp_uuid",  64'(rsp_uuid),  64'(re.uuid));
                    chk("rsp_tmask", 64'(rsp_tmask), 64'(re.tmask));
                    if (stall_req > 0) begin
                        r = 1'b0;
                        stall_req--;
                    end else begin
                        r = ($urandom_range(0, 99) < 50);
                    end
                    rsp_ready = r;
                    held      = {rsp_wid, rsp_uuid, rsp_tmask};
                    seen      = !r;
                    stalled   = !r;
                    if (r) re = rq.pop_front();
                end
            end else begin
                rsp_ready = 1'($urandom_range(0, 1));
                if (rq.size() > 0 && rq[0].cyc <= cyc) begin
                    re = rq.pop_front();
                    chk("rsp_missing", 64'(0), 64'(1));
                end
            end
        end
    end

    task automatic rand_stamp_data();
        for (int l = 0; l < NL; l++) stamp_data[l] = RW'($urandom);
    endtask

    task automatic wait_idle(output bit ok);
        int guard = 0;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        ok = req_ready;
        if (!ok) chk("req_ready_timeout", 64'(0), 64'(1));
    endtask

    // Issue one request; the reference model walks the list of non-empty groups.
    // pv/pd: percent chance of stamp_valid/stamp_done per cycle; fm<0 random mask.
    task automatic run_req(input logic [NT-1:0] tm, input logic [NW-1:0] wid,
                           input logic [UW-1:0] uuid, input int pv, input int pd, input int fm);
        int            groups[$];
        int            idx = 0;
        logic [NT-1:0] acc = '0;
        logic [NL-1:0] hit;
        bit            busy;
        bit            ok;
        wr_t           we;
        rsp_t          re;
        for (int g = 0; g < NG; g++) if (|tm[g*NL +: NL]) groups.push_back(g);
        @(negedge clk);
        wait_idle(ok);
        if (!ok) return;
        req_valid = 1'b1;
        req_wid   = wid;
        req_tmask = tm;
        req_uuid  = uuid;
        if (groups.size() == 0) begin
            re = '{wid: wid, uuid: uuid, tmask: '0, cyc: cyc + 1};
            rq.push_back(re);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_tmask = NT'($urandom);
        busy = (groups.size() > 0);
        while (busy) begin
            chk("stamp_ready", 64'(stamp_ready), 64'(1));
            stamp_valid = ($urandom_range(0, 99) < pv);
            stamp_done  = ($urandom_range(0, 99) < pd);
            stamp_mask  = (fm < 0) ? NL'($urandom) : NL'(fm);
            rand_stamp_data();
            if (stamp_valid) begin
                hit = tm[groups[idx]*NL +: NL] & stamp_mask;
                acc[groups[idx]*NL +: NL] = acc[groups[idx]*NL +: NL] | hit;
                we = '{pid: PW'(groups[idx]), tmask: hit, data: stamp_data,
                       wid: wid, uuid: uuid, cyc: cyc + 1};
                wq.push_back(we);
                idx++;
                if (stamp_done || idx == groups.size()) busy = 0;
            end else if (stamp_done) begin
                busy = 0;
            end
            if (!busy) begin
                re = '{wid: wid, uuid: uuid, tmask: acc, cyc: cyc + 1};
                rq.push_back(re);
            end
            @(negedge clk);
        end
        stamp_valid = 1'b0;
        stamp_done  = 1'b0;
        rand_stamp_data();
        chk("stamp_ready_after", 64'(stamp_ready), 64'(0));
    endtask

    // Reset asserted while the second stamp of a full-mask request is pending.
    task automatic reset_mid_fetch();
        bit  ok;
        wr_t we;
        @(negedge clk);
        wait_idle(ok);
        if (!ok) return;
        req_valid = 1'b1;
        req_tmask = 4'b1111;
        req_wid   = 2'd1;
        req_uuid  = 8'h5a;
        @(negedge clk);
        req_valid   = 1'b0;
        stamp_valid = 1'b1;
        stamp_mask  = 2'b11;
        rand_stamp_data();
        we = '{pid: '0, tmask: 2'b11, data: stamp_data, wid: 2'd1, uuid: 8'h5a, cyc: cyc + 1};
        wq.push_back(we);
        @(negedge clk);
        stamp_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_write_enable", 64'(write_enable), 64'(0));
        chk("rst_rsp_valid",    64'(rsp_valid),    64'(0));
        chk("rst_req_ready",    64'(req_ready),    64'(0));
        chk("rst_stamp_ready",  64'(stamp_ready),  64'(0));
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", 64'(req_ready), 64'(1));
        for (int i = 0; i < 4; i++) @(negedge clk);
    endtask

    initial begin
        bit ok;
        #2;
        chk("reset_req_ready",    64'(req_ready),    64'(0));
        chk("reset_stamp_ready",  64'(stamp_ready),  64'(0));
        chk("reset_write_enable", 64'(write_enable), 64'(0));
        chk("reset_rsp_valid",    64'(rsp_valid),    64'(0));
        chk("reset_rsp_tmask",    64'(rsp_tmask),    64'(0));
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("release_req_ready", 64'(req_ready), 64'(1));

        run_req(4'b1111, 2'd3, 8'h11, 100, 0, 3);
        run_req(4'b1100, 2'd2, 8'h22, 100, 0, 3);
        run_req(4'b1111, 2'd1, 8'h33, 100, 100, 1);
        run_req(4'b0000, 2'd0, 8'h44, 100, 0, -1);
        stall_req = 5;
        run_req(4'b0110, 2'd3, 8'h55, 100, 0, -1);
        for (int i = 0; i < 60; i++) begin
            run_req(NT'($urandom), NW'($urandom), UW'($urandom),
                    $urandom_range(30, 100), $urandom_range(0, 15), -1);
        end
        reset_mid_fetch();
        run_req(4'b1011, 2'd2, 8'h66, 70, 0, -1);

        @(negedge clk);
        wait_idle(ok);
        repeat (3) @(negedge clk);
        chk("drain_writes", 64'(wq.size()), 64'(0));
        chk("drain_rsps",   64'(rq.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
